countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Down-counting HH:MM:SS timer: the decrementing counterpart of the up-counting time-of-day clock chain.
- Loaded with a preset duration, decrements once per clk_1Hz tick, and raises an alarm on reaching 00:00:00.
- Fully synchronous single-clock design with a borrow chain; no ripple clocking.
- Feeds the same display path as the clock: hours, minutes, seconds as binary values.

Parameters:
HRS_MAX, 23, largest loadable hours value; load values above it are clamped.
ALARM_SECS, 10, number of clk_1Hz cycles alarm stays high before auto-return to IDLE (1..63).

Ports:
clk_1Hz  input  1  timer tick clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; forces IDLE, count 00:00:00
clear  input  1  sampled level; synchronous return to IDLE with count zeroed
load  input  1  sampled level; captures set_* into count (IDLE/PAUSED only)
start  input  1  sampled level; start/resume counting; acknowledges alarm
pause  input  1  sampled level; freezes count while running
set_hours  input  5  preset hours
set_minutes  input  6  preset minutes
set_seconds  input  6  preset seconds
hours  output  5  current hours remaining
minutes  output  6  current minutes remaining
seconds  output  6  current seconds remaining
running  output  1  high while state is RUN
alarm  output  1  high while state is ALARM
done_pulse  output  1  one-cycle pulse on the edge where count reaches zero

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk_1Hz. While reset is high: state IDLE, hours/minutes/seconds = 0, running = 0, alarm = 0, done_pulse = 0, alarm counter = 0.
- All outputs are registered; values reflect the state after each rising edge. Zero combinational paths from inputs to outputs.
- Control priority per edge: clear > load > pause > start.
- States: IDLE, RUN, PAUSED, ALARM.
- IDLE:
  - load captures presets; stays IDLE.
  - start with nonzero count goes to RUN. No decrement on that edge; first decrement is on the next edge.
  - start with zero count is ignored: stay IDLE, no alarm.
- RUN: decrement every edge unless pause is high.
  - seconds > 0: seconds - 1.
  - seconds = 0: seconds = 59 and minutes borrows.
  - minutes = 0 on borrow: minutes = 59 and hours - 1.
  - Borrow below 00:00:00 cannot occur.
  - Transition on the edge where count goes 00:00:01 -> 00:00:00: next state ALARM, alarm = 1, done_pulse = 1 for exactly that cycle.
  - pause high: go to PAUSED and hold count; pause wins over a simultaneous start.
  - load is ignored in RUN.
- PAUSED:
  - Count frozen.
  - load captures presets; stays PAUSED.
  - start with pause low and nonzero count goes to RUN.
  - start with zero count goes to IDLE.
- ALARM:
  - Count held at 0; alarm counter increments each edge.
  - After ALARM_SECS cycles in ALARM, go to IDLE and clear alarm.
  - start or clear goes to IDLE immediately (acknowledge); load is ignored.
- clear in any state: IDLE, count 0, alarm 0, done_pulse 0 on that edge.
- Clamping on load: seconds > 59 -> 59, minutes > 59 -> 59, hours > HRS_MAX -> HRS_MAX. Each field is clamped independently.
- Reset asserted mid-RUN or mid-ALARM aborts immediately, with no done_pulse.
- done_pulse never fires on load, clear, or reset, even if the count becomes zero.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN, PAUSED, ALARM)
  - constants SEC_MAX = 59, MIN_MAX = 59
  - field widths (HRS_W = 5, MS_W = 6)
- Sub-module down_digit: one mod-N down-counter field.
  - Inputs: max, load, load_val, dec_en.
  - Outputs: val, borrow_out (asserted when val = 0 and dec_en).
  - Instantiated three times, chained seconds -> minutes -> hours.
- The FSM and alarm counter live in the top level.

Test Plan:
1. Load 00:00:03, then start -> run/0 sequence: 00:00:03, 00:00:02, 00:00:01, 00:00:00. done_pulse high only on the edge reaching zero; alarm high for 10 cycles; then IDLE with alarm = 0.
2. Load 01:00:00, start, one tick -> 00:59:59 (double borrow). A further tick -> 00:59:58.
3. Run from 00:05:00. After 2 ticks assert pause for 3 cycles -> count holds at 00:04:58. Deassert pause and assert start -> resumes at 00:04:57 on the next edge.
4. Clamping: load set_hours = 31, set_minutes = 63, set_seconds = 60 -> 23:59:59. Load 00:00:00 then start -> stays IDLE, alarm never asserts.
5. In ALARM after 2 cycles, assert start -> IDLE next edge, alarm = 0. Separately, assert pause and start together in RUN -> PAUSED.
6. Assert reset asynchronously mid-RUN at 00:10:07 -> outputs 0 immediately, without waiting for an edge; no done_pulse. After deassertion, start is ignored until a load.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and field constants for the HH:MM:SS countdown timer.
package timer_pkg;

    localparam int HRS_W = 5;
    localparam int MS_W  = 6;

    localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MS_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_ALARM  = 2'd3
    } state_e;

    function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v,
                                                 input logic [MS_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/down_digit.sv
// One modulo-(max+1) down-counting field; borrow_out asks the next field to decrement.
module down_digit #(
    parameter int W = 6
) (
    input  logic         clk_1Hz,
    input  logic         reset,
    input  logic [W-1:0] max,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic [W-1:0] val,
    output logic         borrow_out
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = load_val;
        end else if (dec_en) begin
            val_d = (val_q == '0) ? max : (val_q - 1'b1);
        end
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val        = val_q;
    assign borrow_out = dec_en && (val_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer: three chained down_digit fields plus the run/pause/alarm FSM.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int HRS_MAX    = 23,
    parameter int ALARM_SECS = 10
) (
    input  logic         clk_1Hz,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         start,
    input  logic         pause,
    input  logic [4:0]   set_hours,
    input  logic [5:0]   set_minutes,
    input  logic [5:0]   set_seconds,
    output logic [4:0]   hours,
    output logic [5:0]   minutes,
    output logic [5:0]   seconds,
    output logic         running,
    output logic         alarm,
    output logic         done_pulse
);

    localparam logic [HRS_W-1:0] HRS_MAX_V  = HRS_W'(HRS_MAX);
    localparam logic [5:0]       ALARM_LAST = 6'(ALARM_SECS - 1);

    state_e     state_q, state_d;
    logic [5:0] alarm_cnt_q, alarm_cnt_d;
    logic       done_q, done_d;

    logic             cnt_load;
    logic             dec_en;
    logic [HRS_W-1:0] load_h;
    logic [MS_W-1:0]  load_m, load_s;
    logic             sec_borrow, min_borrow, unused_hrs_borrow;
    logic             cnt_zero, cnt_one;

    assign cnt_zero = (hours == '0) && (minutes == '0) && (seconds == '0);
    assign cnt_one  = (hours == '0) && (minutes == '0) && (seconds == 6'd1);

    always_comb begin
        state_d     = state_q;
        alarm_cnt_d = alarm_cnt_q;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        dec_en      = 1'b0;
        load_h      = (set_hours > HRS_MAX_V) ? HRS_MAX_V : set_hours;
        load_m      = clamp_ms(set_minutes, MIN_MAX);
        load_s      = clamp_ms(set_seconds, SEC_MAX);

        if (clear) begin
            state_d     = ST_IDLE;
            alarm_cnt_d = '0;
            cnt_load    = 1'b1;
            load_h      = '0;
            load_m      = '0;
            load_s      = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        cnt_load = 1'b1;
                    end else if (!pause && start && !cnt_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        dec_en = 1'b1;
                        if (cnt_one) begin
                            state_d     = ST_ALARM;
                            done_d      = 1'b1;
                            alarm_cnt_d = '0;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (load) begin
                        cnt_load = 1'b1;
                    end else if (!pause && start) begin
                        state_d = cnt_zero ? ST_IDLE : ST_RUN;
                    end
                end
                ST_ALARM: begin
                    // start acknowledges; otherwise the alarm times out by itself
                    if (start || (alarm_cnt_q == ALARM_LAST)) begin
                        state_d     = ST_IDLE;
                        alarm_cnt_d = '0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + 6'd1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    alarm_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            alarm_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm_cnt_q <= alarm_cnt_d;
            done_q      <= done_d;
        end
    end

    down_digit #(.W(MS_W)) u_sec (
        .clk_1Hz    (clk_1Hz),
        .reset      (reset),
        .max        (SEC_MAX),
        .load       (cnt_load),
        .load_val   (load_s),
        .dec_en     (dec_en),
        .val        (seconds),
        .borrow_out (sec_borrow)
    );

    down_digit #(.W(MS_W)) u_min (
        .clk_1Hz    (clk_1Hz),
        .reset      (reset),
        .max        (MIN_MAX),
        .load       (cnt_load),
        .load_val   (load_m),
        .dec_en     (sec_borrow),
        .val        (minutes),
        .borrow_out (min_borrow)
    );

    // Hours never borrow below zero; its borrow output is intentionally left dangling.
    down_digit #(.W(HRS_W)) u_hrs (
        .clk_1Hz    (clk_1Hz),
        .reset      (reset),
        .max        (HRS_MAX_V),
        .load       (cnt_load),
        .load_val   (load_h),
        .dec_en     (min_borrow),
        .val        (hours),
        .borrow_out (unused_hrs_borrow)
    );

    assign running    = (state_q == ST_RUN);
    assign alarm      = (state_q == ST_ALARM);
    assign done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a total-seconds reference model.
module tb_countdown_timer;

    logic       clk_1Hz;
    logic       reset;
    logic       clear;
    logic       load;
    logic       start;
    logic       pause;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       alarm;
    logic       done_pulse;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_ALARM = 3;
    localparam int ALARM_LEN = 10;
    localparam int HRS_LIMIT = 23;

    // Reference model: remaining time as one integer of seconds
    int m_t, m_mode, m_acnt;
    bit m_done;

    countdown_timer dut (
        .clk_1Hz     (clk_1Hz),
        .reset       (reset),
        .clear       (clear),
        .load        (load),
        .start       (start),
        .pause       (pause),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_seconds (set_seconds),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .running     (running),
        .alarm       (alarm),
        .done_pulse  (done_pulse)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    function automatic int min_int(input int a, input int b);
        return (a > b) ? b : a;
    endfunction

    function automatic logic [19:0] pack(input int h, input int m, input int s,
                                         input bit r, input bit a, input bit d);
        return {5'(h), 6'(m), 6'(s), r, a, d};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {hours, minutes, seconds, running, alarm, done_pulse};
    endfunction

    function automatic logic [19:0] model_vec();
        return pack(m_t / 3600, (m_t / 60) % 60, m_t % 60,
                    m_mode == M_RUN, m_mode == M_ALARM, m_done);
    endfunction

    task automatic model_reset();
        m_t = 0; m_mode = M_IDLE; m_acnt = 0; m_done = 0;
    endtask

    task automatic model_step(input bit c, input bit l, input bit p, input bit s,
                              input int sh, input int sm, input int ss);
        int preset;
        preset = min_int(sh, HRS_LIMIT) * 3600 + min_int(sm, 59) * 60 + min_int(ss, 59);
        m_done = 0;
        if (c) begin
            m_mode = M_IDLE; m_t = 0; m_acnt = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (l) m_t = preset;
                    else if (!p && s && m_t != 0) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (p) m_mode = M_PAUSED;
                    else begin
                        m_t = m_t - 1;
                        if (m_t == 0) begin m_mode = M_ALARM; m_done = 1; m_acnt = 0; end
                    end
                end
                M_PAUSED: begin
                    if (l) m_t = preset;
                    else if (!p && s) m_mode = (m_t != 0) ? M_RUN : M_IDLE;
                end
                default: begin
                    if (s) begin m_mode = M_IDLE; m_acnt = 0; end
                    else begin
                        m_acnt = m_acnt + 1;
                        if (m_acnt == ALARM_LEN) begin m_mode = M_IDLE; m_acnt = 0; end
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed h:m:s:r:a:d=%0d:%0d:%0d:%b%b%b required %0d:%0d:%0d:%b%b%b",
                   tag, obs[19:15], obs[14:9], obs[8:3], obs[2], obs[1], obs[0],
                   exp[19:15], exp[14:9], exp[8:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one edge's inputs, advance the model, compare #1 after the edge.
    task automatic step(input string tag, input bit c, input bit l, input bit p, input bit s,
                        input int sh, input int sm, input int ss);
        clear = c; load = l; pause = p; start = s;
        set_hours = 5'(sh); set_minutes = 6'(sm); set_seconds = 6'(ss);
        @(posedge clk_1Hz);
        model_step(c, l, p, s, sh, sm, ss);
        #1;
        check(tag, dut_vec(), model_vec());
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; clear = 0; load = 0; start = 0; pause = 0;
        set_hours = '0; set_minutes = '0; set_seconds = '0;
        model_reset();
        #12;
        check("reset_state", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        // Short run to zero, alarm hold, auto-return
        step("t1_load", 0, 1, 0, 0, 0, 0, 3);
        step("t1_start", 0, 0, 0, 1, 0, 0, 0);
        check("t1_start_no_dec", dut_vec(), pack(0, 0, 3, 1, 0, 0));
        idle("t1_tick2");
        idle("t1_tick1");
        idle("t1_zero");
        check("t1_done_edge", dut_vec(), pack(0, 0, 0, 0, 1, 1));
        for (int i = 0; i < ALARM_LEN - 1; i++) idle("t1_alarm_hold");
        check("t1_alarm_last", dut_vec(), pack(0, 0, 0, 0, 1, 0));
        idle("t1_alarm_end");
        check("t1_back_idle", dut_vec(), pack(0, 0, 0, 0, 0, 0));

        // Double borrow
        step("t2_load", 0, 1, 0, 0, 1, 0, 0);
        step("t2_start", 0, 0, 0, 1, 0, 0, 0);
        idle("t2_tick");
        check("t2_double_borrow", dut_vec(), pack(0, 59, 59, 1, 0, 0));
        idle("t2_tick2");
        check("t2_after_borrow", dut_vec(), pack(0, 59, 58, 1, 0, 0));
        step("t2_clear", 1, 0, 0, 0, 0, 0, 0);

        // Pause and resume
        step("t3_load", 0, 1, 0, 0, 0, 5, 0);
        step("t3_start", 0, 0, 0, 1, 0, 0, 0);
        idle("t3_tick");
        idle("t3_tick");
        for (int i = 0; i < 3; i++) step("t3_pause", 0, 0, 1, 0, 0, 0, 0);
        check("t3_paused_hold", dut_vec(), pack(0, 4, 58, 0, 0, 0));
        step("t3_resume", 0, 0, 0, 1, 0, 0, 0);
        check("t3_resume_edge", dut_vec(), pack(0, 4, 58, 1, 0, 0));
        idle("t3_tick");
        check("t3_resumed", dut_vec(), pack(0, 4, 57, 1, 0, 0));
        step("t3_clear", 1, 0, 0, 0, 0, 0, 0);

        // Clamping and start-on-zero
        step("t4_clamp", 0, 1, 0, 0, 31, 63, 60);
        check("t4_clamped", dut_vec(), pack(23, 59, 59, 0, 0, 0));
        step("t4_load_zero", 0, 1, 0, 0, 0, 0, 0);
        step("t4_start_zero", 0, 0, 0, 1, 0, 0, 0);
        idle("t4_stay");
        check("t4_no_alarm", dut_vec(), pack(0, 0, 0, 0, 0, 0));

        // Alarm acknowledge, pause beats start
        step("t5_load", 0, 1, 0, 0, 0, 0, 2);
        step("t5_start", 0, 0, 0, 1, 0, 0, 0);
        idle("t5_tick");
        idle("t5_zero");
        idle("t5_alarm1");
        idle("t5_alarm2");
        step("t5_ack", 0, 0, 0, 1, 0, 0, 0);
        check("t5_acked", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        step("t5_load2", 0, 1, 0, 0, 0, 0, 20);
        step("t5_start2", 0, 0, 0, 1, 0, 0, 0);
        idle("t5_tick2");
        step("t5_pause_start", 0, 0, 1, 1, 0, 0, 0);
        check("t5_pause_wins", dut_vec(), pack(0, 0, 19, 0, 0, 0));
        step("t5_clear", 1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run
        step("t6_load", 0, 1, 0, 0, 0, 10, 10);
        step("t6_start", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle("t6_tick");
        check("t6_pre_reset", dut_vec(), pack(0, 10, 7, 1, 0, 0));
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("t6_async_reset", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        #3 reset = 1'b0;
        step("t6_start_ignored", 0, 0, 0, 1, 0, 0, 0);
        idle("t6_still_idle");
        check("t6_idle_zero", dut_vec(), pack(0, 0, 0, 0, 0, 0));

        // Randomized control traffic against the model
        for (int i = 0; i < 800; i++) begin
            bit c, l, p, s;
            int sh, sm, ss;
            c  = ($urandom_range(0, 99) < 2);
            l  = ($urandom_range(0, 99) < 8);
            p  = ($urandom_range(0, 99) < 8);
            s  = ($urandom_range(0, 99) < 20);
            sh = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 31) : 0;
            sm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : 0;
            ss = $urandom_range(0, 63);
            step("rand", c, l, p, s, sh, sm, ss);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
